// File: rtl/adam_aes_key_expander_if.sv
// Key-expander request/response bundle: key request handshake in, round-key schedule out.
// The master drives the request side; the slave (the expander) drives status and round keys.
interface adam_aes_key_expander_if;
    logic         start;
    logic         keylen;
    logic [127:0] key;
    logic         ready;
    logic         valid;
    logic         error;
    logic [127:0] round_keys [0:10];

    modport master (
        output start, keylen, key,
        input  ready, valid, error, round_keys
    );

    modport slave (
        input  start, keylen, key,
        output ready, valid, error, round_keys
    );
endinterface

// File: rtl/adam_aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per cycle, 11 cycles from accepting start to valid.
// Start is taken only while ready; start during expansion is dropped, never queued.
module adam_aes_key_expander (
    input  logic                      clk,
    input  logic                      reset,
    adam_aes_key_expander_if.slave    bus
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // FIPS-197 S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
        logic [10:0] idx;
        idx = {~a, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state;
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    assign prev_idx = rnd - 4'd1;

    always_comb begin
        prev_key = '0;
        if (prev_idx <= 4'd10) begin
            prev_key = bus.round_keys[prev_idx];
        end
    end

    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    // Four shared S-box lookups form SubWord.
    for (genvar g = 0; g < 4; g++) begin : g_subword
        assign sub_word[8*g +: 8] = sbox_lookup(rot_word[8*g +: 8]);
    end

    assign temp_word = sub_word ^ {rcon, 24'h000000};
    assign n0        = prev_key[127:96] ^ temp_word;
    assign n1        = prev_key[95:64]  ^ n0;
    assign n2        = prev_key[63:32]  ^ n1;
    assign n3        = prev_key[31:0]   ^ n2;
    assign next_key  = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            rcon      <= 8'h01;
            bus.ready <= 1'b1;
            bus.valid <= 1'b0;
            bus.error <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                bus.round_keys[i] <= '0;
            end
        end else begin
            bus.error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.keylen) begin
                            bus.error <= 1'b1;
                        end else begin
                            bus.round_keys[0] <= bus.key;
                            rnd               <= 4'd1;
                            rcon              <= 8'h01;
                            bus.valid         <= 1'b0;
                            bus.ready         <= 1'b0;
                            state             <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    bus.round_keys[rnd] <= next_key;
                    rcon                <= xtime(rcon);
                    if (rnd == 4'd10) begin
                        rnd       <= 4'd0;
                        bus.ready <= 1'b1;
                        bus.valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
